// File: rtl/npu_pkg.sv
// Shared NPU definitions: sequencer state encoding, 3x3 tap indices
// and the feature-map geometry defaults used by Memory and Control.
package npu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } seq_state_t;

    localparam int TAP_TL = 8;
    localparam int TAP_T  = 7;
    localparam int TAP_TR = 6;
    localparam int TAP_L  = 5;
    localparam int TAP_C  = 4;
    localparam int TAP_R  = 3;
    localparam int TAP_BL = 2;
    localparam int TAP_B  = 1;
    localparam int TAP_BR = 0;

    localparam int FMAP_W   = 80;
    localparam int FMAP_H   = 8;
    localparam int FMAP_W_B = 7;
    localparam int FMAP_H_B = 3;
    localparam int FMAP_C   = 1;
    localparam int FMAP_C_B = 1;

endpackage

// File: rtl/pad_mask_gen.sv
// Same-padding tap mask for a 3x3 window centred at (row, col):
// a tap is enabled only when it falls inside the feature map.
module pad_mask_gen
    import npu_pkg::*;
#(
    parameter int width    = FMAP_W,
    parameter int height   = FMAP_H,
    parameter int width_b  = FMAP_W_B,
    parameter int height_b = FMAP_H_B
) (
    input  logic [height_b-1:0] row,
    input  logic [width_b-1:0]  col,
    output logic [8:0]          mask
);

    localparam logic [height_b-1:0] ROW_MAX = height_b'(height - 1);
    localparam logic [width_b-1:0]  COL_MAX = width_b'(width - 1);

    logic up, dn, lf, rt;

    assign up = (row != '0);
    assign dn = (row != ROW_MAX);
    assign lf = (col != '0);
    assign rt = (col != COL_MAX);

    always_comb begin
        mask         = '0;
        mask[TAP_TL] = up & lf;
        mask[TAP_T]  = up;
        mask[TAP_TR] = up & rt;
        mask[TAP_L]  = lf;
        mask[TAP_C]  = 1'b1;
        mask[TAP_R]  = rt;
        mask[TAP_BL] = dn & lf;
        mask[TAP_B]  = dn;
        mask[TAP_BR] = dn & rt;
    end

endmodule

// File: rtl/fmap_read_sequencer.sv
// Raster-order window issuer for the fmap/bias read path; every output
// is registered straight from the next-state counters.
module fmap_read_sequencer
    import npu_pkg::*;
#(
    parameter int width    = FMAP_W,
    parameter int height   = FMAP_H,
    parameter int width_b  = FMAP_W_B,
    parameter int height_b = FMAP_H_B,
    parameter int chans    = FMAP_C,
    parameter int chans_b  = FMAP_C_B
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    output logic [height_b-1:0] row_addr,
    output logic [width_b-1:0]  col_addr,
    output logic [chans_b-1:0]  ch_addr,
    output logic [8:0]          en_read,
    output logic                en_bias,
    output logic                valid,
    output logic                last,
    output logic                busy,
    output logic                done
);

    localparam logic [height_b-1:0] ROW_MAX = height_b'(height - 1);
    localparam logic [width_b-1:0]  COL_MAX = width_b'(width - 1);
    localparam logic [chans_b-1:0]  CH_MAX  = chans_b'(chans - 1);

    seq_state_t state, state_n;

    logic [height_b-1:0] row_n;
    logic [width_b-1:0]  col_n;
    logic [chans_b-1:0]  ch_n;
    logic [8:0]          mask_n;
    logic                run_n;
    logic                valid_q;

    pad_mask_gen #(
        .width   (width),
        .height  (height),
        .width_b (width_b),
        .height_b(height_b)
    ) u_mask (
        .row (row_n),
        .col (col_n),
        .mask(mask_n)
    );

    always_comb begin
        state_n = state;
        row_n   = row_addr;
        col_n   = col_addr;
        ch_n    = ch_addr;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    row_n   = '0;
                    col_n   = '0;
                    ch_n    = '0;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (ch_addr == CH_MAX) begin
                        ch_n = '0;
                        if (col_addr == COL_MAX) begin
                            col_n = '0;
                            if (row_addr == ROW_MAX) begin
                                row_n   = '0;
                                state_n = ST_DONE;
                            end else begin
                                row_n = row_addr + 1'b1;
                            end
                        end else begin
                            col_n = col_addr + 1'b1;
                        end
                    end else begin
                        ch_n = ch_addr + 1'b1;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign run_n = (state_n == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            row_addr <= '0;
            col_addr <= '0;
            ch_addr  <= '0;
            en_read  <= '0;
            en_bias  <= 1'b0;
            last     <= 1'b0;
            valid_q  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            row_addr <= row_n;
            col_addr <= col_n;
            ch_addr  <= ch_n;
            en_read  <= run_n ? mask_n : 9'h000;
            en_bias  <= run_n && (ch_n == '0);
            last     <= run_n && (row_n == ROW_MAX) &&
                        (col_n == COL_MAX) && (ch_n == CH_MAX);
            valid_q  <= run_n;
            done     <= (state_n == ST_DONE);
        end
    end

    assign valid = valid_q;
    assign busy  = valid_q;

endmodule

// File: tb/tb_fmap_read_sequencer.sv
// Checks two sequencers (1 and 3 channel passes) against a window-index
// model, plus fixed corner/edge, stall and reset expectations.
module tb_fmap_read_sequencer;

    localparam int W = 80;
    localparam int H = 8;

    logic clk, rst_n, start, stall;

    logic [2:0] row0, row1;
    logic [6:0] col0, col1;
    logic [0:0] ch0;
    logic [1:0] ch1;
    logic [8:0] rd0, rd1;
    logic bias0, val0, last0, busy0, done0;
    logic bias1, val1, last1, busy1, done1;

    fmap_read_sequencer u_d0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .row_addr(row0), .col_addr(col0), .ch_addr(ch0),
        .en_read(rd0), .en_bias(bias0), .valid(val0),
        .last(last0), .busy(busy0), .done(done0)
    );

    fmap_read_sequencer #(.chans(3), .chans_b(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .row_addr(row1), .col_addr(col1), .ch_addr(ch1),
        .en_read(rd1), .en_bias(bias1), .valid(val1),
        .last(last1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int vcnt0 = 0;
    int vcnt1 = 0;

    int ph[2];
    int k[2];
    int nch[2] = '{1, 3};

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] exp_mask(input int r, input int c);
        logic [8:0] m = '0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
                    m[8 - (3 * (dr + 1) + (dc + 1))] = 1'b1;
        return m;
    endfunction

    // Model: phase 0 idle, 1 run, 2 done; k counts accepted windows.
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                ph[d] <= 0;
                k[d]  <= 0;
            end else if (ph[d] == 0) begin
                if (start) begin
                    ph[d] <= 1;
                    k[d]  <= 0;
                end
            end else if (ph[d] == 1) begin
                if (!stall) begin
                    if (k[d] == H * W * nch[d] - 1) ph[d] <= 2;
                    else k[d] <= k[d] + 1;
                end
            end else begin
                ph[d] <= 0;
            end
        end
    end

    task automatic cmp(input int d, input int r, input int c, input int ch,
                       input int rd, input int bi, input int va,
                       input int la, input int bu, input int dn);
        bit run = (ph[d] == 1);
        int C = nch[d];
        int ech = run ? k[d] % C : 0;
        int ecol = run ? (k[d] / C) % W : 0;
        int erow = run ? k[d] / (C * W) : 0;
        string p = (d == 0) ? "d0_" : "d1_";
        chk({p, "row"}, r, erow);
        chk({p, "col"}, c, ecol);
        chk({p, "ch"}, ch, ech);
        chk({p, "en_read"}, rd, run ? int'(exp_mask(erow, ecol)) : 0);
        chk({p, "en_bias"}, bi, int'(run && ech == 0));
        chk({p, "valid"}, va, int'(run));
        chk({p, "busy"}, bu, int'(run));
        chk({p, "last"}, la, int'(run && k[d] == H * W * C - 1));
        chk({p, "done"}, dn, int'(ph[d] == 2));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp(0, row0, col0, ch0, rd0, bias0, val0, last0, busy0, done0);
            cmp(1, row1, col1, ch1, rd1, bias1, val1, last1, busy1, done1);
            if (val0) vcnt0++;
            if (val1) vcnt1++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int d, input int bound);
        int n = 0;
        while (((d == 0) ? done0 : done1) !== 1'b1 && n < bound) begin
            step(1);
            n++;
        end
        chk((d == 0) ? "d0_done_seen" : "d1_done_seen",
            (d == 0) ? done0 : done1, 1);
    endtask

    int s0, s1, n;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        step(3);
        rst_n = 1'b1;
        stall = 1'b1;
        step(5);
        stall = 1'b0;
        chk("idle_busy", busy0, 0);
        chk("idle_done", done0, 0);
        chk("idle_en_read", rd0, 0);

        // Sweep 1: corners and channel passes, start pulsed mid-sweep
        s0 = vcnt0; s1 = vcnt1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("c0_en_read", rd0, 9'h01B);
        chk("c0_valid", val0, 1);
        chk("c0_bias", bias0, 1);
        chk("c0_d1_ch", ch1, 0);
        step(1);
        chk("c1_d1_ch", ch1, 1);
        chk("c1_d1_bias", bias1, 0);
        chk("c1_d1_en_read", rd1, 9'h01B);
        step(1);
        chk("c2_d1_ch", ch1, 2);
        step(1);
        chk("c3_d1_col", col1, 1);
        chk("c3_d1_en_read", rd1, 9'h03F);
        step(2);
        chk("c5_col", col0, 5);
        chk("c5_en_read", rd0, 9'h03F);
        step(275);
        chk("c280_row", row0, 3);
        chk("c280_col", col0, 40);
        chk("c280_en_read", rd0, 9'h1FF);
        step(20);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("c301_row", row0, 3);
        chk("c301_col", col0, 61);
        step(338);
        chk("c639_row", row0, 7);
        chk("c639_col", col0, 79);
        chk("c639_last", last0, 1);
        chk("c639_en_read", rd0, 9'h1B0);
        step(1);
        chk("c640_done", done0, 1);
        chk("c640_valid", val0, 0);
        step(1);
        chk("c641_done", done0, 0);
        wait_done(1, 1400);
        chk("d0_windows", vcnt0 - s0, 640);
        chk("d1_windows", vcnt1 - s1, 1920);
        step(2);

        // Sweep 2: four stalled cycles at (2,10)
        s0 = vcnt0; s1 = vcnt1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(170);
        chk("st_row", row0, 2);
        chk("st_col", col0, 10);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("st_hold_col", col0, 10);
            chk("st_hold_mask", rd0, 9'h1FF);
        end
        stall = 1'b0;
        step(1);
        chk("st_resume_col", col0, 11);
        wait_done(0, 1000);
        chk("d0_run_len", vcnt0 - s0, 644);
        wait_done(1, 1400);
        chk("d1_run_len", vcnt1 - s1, 1924);
        step(2);

        // Sweep 3: asynchronous reset at (4,0), then restart
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(320);
        chk("rs_row", row0, 4);
        chk("rs_col", col0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_valid", val0, 0);
        chk("rs_row0", row0, 0);
        chk("rs_en_read", rd0, 0);
        chk("rs_d1_valid", val1, 0);
        step(3);
        chk("rs_no_done", done0, 0);
        rst_n = 1'b1;
        step(2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("rs_restart_col", col0, 0);
        chk("rs_restart_valid", val0, 1);
        chk("rs_restart_mask", rd0, 9'h01B);

        // Random stall / start traffic, then drain
        for (int i = 0; i < 4000; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 15) == 0);
            step(1);
        end
        stall = 1'b0;
        start = 1'b0;
        n = 0;
        while ((busy0 || busy1) && n < 3000) begin
            step(1);
            n++;
        end
        chk("drain_busy", int'(busy0 || busy1), 0);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
